// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lends one shared combinational ALU to two requesters.
// Each accepted operation runs for one EXEC cycle and its registered result is held until its owner takes it.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Req0_Valid,
  output logic             Req0_Ready,
  input  logic [3:0]       Req0_Control,
  input  logic [WIDTH-1:0] Req0_A,
  input  logic [WIDTH-1:0] Req0_B,
  input  logic             Req1_Valid,
  output logic             Req1_Ready,
  input  logic [3:0]       Req1_Control,
  input  logic [WIDTH-1:0] Req1_A,
  input  logic [WIDTH-1:0] Req1_B,
  output logic             Resp0_Valid,
  input  logic             Resp0_Ready,
  output logic             Resp1_Valid,
  input  logic             Resp1_Ready,
  output logic [WIDTH-1:0] Resp_Out,
  output logic             Resp_Zero,
  output logic             Resp_Illegal,
  output logic [3:0]       Alu_Control,
  output logic [WIDTH-1:0] Alu_In1,
  output logic [WIDTH-1:0] Alu_In2,
  input  logic [WIDTH-1:0] Alu_Out,
  input  logic             Alu_Zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic             owner_r;
  logic             last_r;
  logic [3:0]       ctrl_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] out_r;
  logic             zero_r;
  logic             ill_r;
  logic             grant0_s;
  logic             grant1_s;
  logic             xfer0_s;
  logic             xfer1_s;
  logic             resp_done_s;

  function automatic logic is_illegal(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: is_illegal = 1'b0;
      default:                             is_illegal = 1'b1;
    endcase
  endfunction

  // Round-robin grant; last_r==1 means requester 0 wins a tie.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (Req0_Valid && Req1_Valid) begin
      grant0_s = last_r;
      grant1_s = ~last_r;
    end else begin
      grant0_s = Req0_Valid;
      grant1_s = Req1_Valid;
    end
  end

  // Handshake outputs: ready only while idle, response valid only for the owner.
  always_comb begin
    Req0_Ready  = (state_r == IDLE) && grant0_s;
    Req1_Ready  = (state_r == IDLE) && grant1_s;
    xfer0_s     = Req0_Ready && Req0_Valid;
    xfer1_s     = Req1_Ready && Req1_Valid;
    Resp0_Valid = (state_r == RESP) && (owner_r == 1'b0);
    Resp1_Valid = (state_r == RESP) && (owner_r == 1'b1);
  end

  // Next-state logic.
  always_comb begin
    state_s     = state_r;
    resp_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (xfer0_s || xfer1_s) state_s = EXEC;
        else                    state_s = IDLE;
      end
      EXEC: state_s = RESP;
      RESP: begin
        resp_done_s = owner_r ? Resp1_Ready : Resp0_Ready;
        if (resp_done_s) state_s = IDLE;
        else             state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Operand and owner capture on transfer.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      ctrl_r  <= 4'd0;
      a_r     <= '0;
      b_r     <= '0;
      owner_r <= 1'b0;
    end else if (xfer0_s) begin
      ctrl_r  <= Req0_Control;
      a_r     <= Req0_A;
      b_r     <= Req0_B;
      owner_r <= 1'b0;
    end else if (xfer1_s) begin
      ctrl_r  <= Req1_Control;
      a_r     <= Req1_A;
      b_r     <= Req1_B;
      owner_r <= 1'b1;
    end else begin
      ctrl_r  <= ctrl_r;
      a_r     <= a_r;
      b_r     <= b_r;
      owner_r <= owner_r;
    end
  end

  // Result capture at the end of EXEC, held through RESP.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      out_r  <= '0;
      zero_r <= 1'b0;
      ill_r  <= 1'b0;
    end else if (state_r == EXEC) begin
      out_r  <= Alu_Out;
      zero_r <= Alu_Zero;
      ill_r  <= is_illegal(ctrl_r);
    end else begin
      out_r  <= out_r;
      zero_r <= zero_r;
      ill_r  <= ill_r;
    end
  end

  // Last-served pointer advances only when a response is consumed.
  always_ff @(posedge Clock) begin
    if (!Reset_n)         last_r <= 1'b1;
    else if (resp_done_s) last_r <= owner_r;
    else                  last_r <= last_r;
  end

  assign Alu_Control  = ctrl_r;
  assign Alu_In1      = a_r;
  assign Alu_In2      = b_r;
  assign Resp_Out     = out_r;
  assign Resp_Zero    = zero_r;
  assign Resp_Illegal = ill_r;

endmodule
